// File: rtl/conv2d_1_filter_sched.sv
// Round-robin merge of NF filter-output FIFOs into one tagged result stream; dst beat 1 cycle after src_rdreq.
// dst_full stalls reads on the current filter without rotating; an empty source ends the grant.
module conv2d_1_filter_sched #(
  parameter int DWIDTH = 32,
  parameter int NF     = 4,
  parameter int PIXELS = 12544,
  parameter int BURST  = 16,
  localparam int TW    = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic [NF*DWIDTH-1:0] src_data,
  input  logic [NF-1:0]        src_empty,
  output logic [NF-1:0]        src_rdreq,
  output logic [DWIDTH-1:0]    dst_data,
  output logic [TW-1:0]        dst_tag,
  output logic                 dst_valid,
  input  logic                 dst_full
);
  localparam int CW = $clog2(PIXELS + 1);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [2:0] {IDLE, SCAN, READ, FLUSH, DONE} state_t;

  state_t            state;
  logic [TW-1:0]     ptr;
  logic [TW-1:0]     ptr_nxt;
  logic [BW-1:0]     burst;
  logic [CW-1:0]     cnt [NF];
  logic              all_done;
  logic              rd_ok;
  logic              last_beat;
  logic [DWIDTH-1:0] src_word [NF];

  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < NF; i++) begin
      src_word[i] = src_data[i*DWIDTH +: DWIDTH];
      if (cnt[i] != CW'(PIXELS)) all_done = 1'b0;
    end
  end

  assign ptr_nxt = (ptr == TW'(NF - 1)) ? '0 : ptr + TW'(1);

  assign rd_ok = (state == READ) && !reset && !src_empty[ptr] && !dst_full &&
                 (burst < BW'(BURST)) && (cnt[ptr] < CW'(PIXELS));

  assign src_rdreq = rd_ok ? (NF'(1) << ptr) : '0;

  // The grant ends on the read that fills the burst or the frame, so SCAN follows immediately.
  assign last_beat = (burst == BW'(BURST - 1)) || (cnt[ptr] == CW'(PIXELS - 1));

  // The source q is valid the cycle after rdreq; the registered tag selects it.
  assign dst_data = dst_valid ? src_word[dst_tag] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      burst     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dst_valid <= 1'b0;
      dst_tag   <= '0;
      for (int i = 0; i < NF; i++) cnt[i] <= '0;
    end else begin
      done      <= 1'b0;
      dst_valid <= rd_ok;
      if (rd_ok) dst_tag <= ptr;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NF; i++) cnt[i] <= '0;
            ptr   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (all_done) begin
            state <= FLUSH;
          end else if ((cnt[ptr] == CW'(PIXELS)) || src_empty[ptr]) begin
            ptr <= ptr_nxt;
          end else begin
            burst <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (rd_ok) begin
            cnt[ptr] <= cnt[ptr] + CW'(1);
            burst    <= burst + BW'(1);
            if (last_beat) begin
              ptr   <= ptr_nxt;
              state <= SCAN;
            end
          end else if (src_empty[ptr] || (burst >= BW'(BURST)) ||
                       (cnt[ptr] == CW'(PIXELS))) begin
            ptr   <= ptr_nxt;
            state <= SCAN;
          end
        end
        FLUSH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_1_filter_sched.sv
// Bench for conv2d_1_filter_sched: FIFO models with 1-cycle q latency, per-filter order scoreboard,
// scenario table (skew, backpressure, sparse, start-while-busy, random) plus reset-mid-frame sequence.
module tb_conv2d_1_filter_sched;
  localparam int DW = 32;
  localparam int NF = 4;
  localparam int PX = 32;
  localparam int BU = 16;
  localparam int TW = $clog2(NF);

  typedef struct {
    int hold_f; int hold_at; int release_at;
    int full_at; int full_len;
    int start_at;
    bit rnd; bit chk_rr;
    int exp_first_held;
    int probe_idx; int probe_tag;
    int exp_per_tag; int exp_done;
  } scen_t;

  logic              clock = 1'b0;
  logic              reset, start, busy, done;
  logic [NF*DW-1:0]  src_data;
  logic [NF-1:0]     src_empty, src_rdreq, raw_empty, hold;
  logic [DW-1:0]     dst_data;
  logic [TW-1:0]     dst_tag;
  logic              dst_valid, dst_full;

  logic [DW-1:0] q_reg [NF];
  logic [DW-1:0] q_next [NF];
  logic [DW-1:0] fq [NF][$];

  int checks = 0, failures = 0, ncyc = 0, frame = 0;
  int got [NF], reads [NF], exp_seq [NF];
  int beats, done_cnt, done_cyc, last_beat_cyc, stall_beats, pend_tag;
  bit pend;
  int tag_log [$];
  scen_t tbl [9];

  conv2d_1_filter_sched #(.DWIDTH(DW), .NF(NF), .PIXELS(PX), .BURST(BU)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .src_data(src_data), .src_empty(src_empty), .src_rdreq(src_rdreq),
    .dst_data(dst_data), .dst_tag(dst_tag), .dst_valid(dst_valid), .dst_full(dst_full)
  );

  always #5 clock = ~clock;

  assign src_empty = raw_empty | hold;
  always_comb for (int i = 0; i < NF; i++) src_data[i*DW +: DW] = q_reg[i];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic logic [31:0] word(input int f, input int fr, input int k);
    return {f[7:0], fr[7:0], k[15:0]};
  endfunction

  function automatic scen_t mk(input int hf, input int ha, input int ra, input int fa, input int fl,
                               input int sa, input bit rn, input bit rr, input int fh,
                               input int pi, input int pt);
    scen_t s;
    s.hold_f = hf; s.hold_at = ha; s.release_at = ra; s.full_at = fa; s.full_len = fl;
    s.start_at = sa; s.rnd = rn; s.chk_rr = rr; s.exp_first_held = fh;
    s.probe_idx = pi; s.probe_tag = pt; s.exp_per_tag = PX; s.exp_done = 1;
    return s;
  endfunction

  // One clock: sample/check at edge+2, then let the FIFO models take the popped words after the edge.
  task automatic step();
    int t;
    #1;
    ncyc++;
    if (reset) begin
      pend = 0;
      chk("rdreq_in_reset", src_rdreq, 0);
    end else begin
      chk("dst_valid_latency", dst_valid, pend);
      if (dst_valid) begin
        t = int'(dst_tag);
        if (pend) chk("dst_tag", t, pend_tag);
        chk("dst_data_order", dst_data, word(t, frame, exp_seq[t]));
        exp_seq[t]++; got[t]++; beats++;
        tag_log.push_back(t);
        last_beat_cyc = ncyc;
        if (dst_full) stall_beats++;
      end
      if (done) begin
        done_cnt++; done_cyc = ncyc;
        chk("busy_low_at_done", busy, 0);
      end
      pend = 0;
      if (src_rdreq != '0) begin
        chk("rdreq_onehot", $countones(src_rdreq), 1);
        chk("rdreq_while_busy", busy, 1);
        chk("rdreq_while_full", dst_full, 0);
        for (int i = 0; i < NF; i++) if (src_rdreq[i]) begin
          chk("rdreq_on_empty", src_empty[i], 0);
          reads[i]++;
          chk("reads_le_pixels", reads[i] <= PX, 1);
          if (fq[i].size() > 0) q_next[i] = fq[i].pop_front();
          pend = 1; pend_tag = i;
        end
      end
    end
    @(posedge clock); #1;
    for (int i = 0; i < NF; i++) begin
      q_reg[i] = q_next[i];
      raw_empty[i] = (fq[i].size() == 0);
    end
  endtask

  task automatic prep_frame();
    frame++;
    for (int i = 0; i < NF; i++) begin
      fq[i].delete();
      for (int k = 0; k < PX; k++) fq[i].push_back(word(i, frame, k));
      got[i] = 0; reads[i] = 0; exp_seq[i] = 0;
    end
    beats = 0; done_cnt = 0; stall_beats = 0; done_cyc = 0; last_beat_cyc = 0;
    tag_log.delete();
    raw_empty = '0;
  endtask

  task automatic run_frame(input scen_t s);
    int b0, full_cnt, other, first_h;
    bit held, released, started;
    b0 = -1; full_cnt = 0; held = 0; released = 0; started = 0;
    prep_frame();
    if (s.hold_f >= 0 && s.hold_at == 0) begin hold[s.hold_f] = 1'b1; held = 1; end
    start = 1'b1; step(); start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      if (s.hold_f >= 0) begin
        other = 0;
        for (int i = 0; i < NF; i++) if (i != s.hold_f) other += reads[i];
        if (!held && reads[s.hold_f] >= s.hold_at) begin
          hold[s.hold_f] = 1'b1; held = 1;
        end else if (held && !released && other >= s.release_at) begin
          hold[s.hold_f] = 1'b0; released = 1;
        end
      end
      if (s.full_at >= 0 && reads[0] >= s.full_at && full_cnt < s.full_len) begin
        if (full_cnt == 0) b0 = beats;
        dst_full = 1'b1; full_cnt++;
      end else if (s.rnd) dst_full = ($urandom_range(0, 3) == 0);
      else dst_full = 1'b0;
      if (s.rnd) for (int i = 0; i < NF; i++) hold[i] = ($urandom_range(0, 4) == 0);
      start = (s.start_at >= 0 && !started && beats >= s.start_at);
      if (start) started = 1;
      step();
    end
    start = 1'b0; dst_full = 1'b0; hold = '0;
    for (int c = 0; c < 4; c++) step();
    chk("done_count", done_cnt, s.exp_done);
    chk("busy_after_done", busy, 0);
    for (int i = 0; i < NF; i++) begin
      chk("beats_per_tag", got[i], s.exp_per_tag);
      chk("reads_per_filter", reads[i], s.exp_per_tag);
    end
    if (s.chk_rr) begin
      for (int k = 0; k < tag_log.size(); k++) chk("rr_tag_order", tag_log[k], (k / BU) % NF);
      chk("done_gap", done_cyc - last_beat_cyc, 2);
    end
    if (s.exp_first_held >= 0) begin
      first_h = -1;
      for (int k = tag_log.size() - 1; k >= 0; k--) if (tag_log[k] == s.hold_f) first_h = k;
      chk("skew_first_held_tag", first_h, s.exp_first_held);
    end
    if (s.full_at >= 0) begin
      chk("stall_beats_le1", stall_beats <= 1, 1);
      chk("stall_resume_ptr", (b0 >= 0 && b0 + 1 < tag_log.size()) ? tag_log[b0 + 1] : -1, 0);
    end
    if (s.probe_idx >= 0)
      chk("probe_tag", (s.probe_idx < tag_log.size()) ? tag_log[s.probe_idx] : -1, s.probe_tag);
    if (s.start_at >= 0) chk("start_pulse_issued", started, 1);
  endtask

  initial begin
    int snap;
    tbl[0] = mk(-1, 0, 0,      -1, 0,  -1, 0, 1, -1,     -1, 0);  // basic round robin
    tbl[1] = mk( 2, 0, 3 * PX, -1, 0,  -1, 0, 0, 3 * PX, -1, 0);  // filter 2 skewed
    tbl[2] = mk(-1, 0, 0,       8, 10, -1, 0, 0, -1,     -1, 0);  // backpressure
    tbl[3] = mk( 0, 5, 1,      -1, 0,  -1, 0, 0, -1,      5, 1);  // sparse filter 0
    tbl[4] = mk(-1, 0, 0,      -1, 0,  20, 0, 0, -1,     -1, 0);  // start while busy
    for (int r = 5; r < 9; r++) tbl[r] = mk(-1, 0, 0, -1, 0, -1, 1, 0, -1, -1, 0);

    reset = 1'b1; start = 1'b0; dst_full = 1'b0; hold = '0; raw_empty = '1; pend = 0;
    for (int i = 0; i < NF; i++) begin q_reg[i] = '0; q_next[i] = '0; got[i] = 0; reads[i] = 0; exp_seq[i] = 0; end
    @(posedge clock); #1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_dst_data", dst_data, 0);
    chk("rst_dst_tag", dst_tag, 0);
    chk("rst_rdreq", src_rdreq, 0);
    reset = 1'b0;
    step(); step();
    chk("idle_without_start", busy, 0);

    for (int s = 0; s < 9; s++) run_frame(tbl[s]);

    prep_frame();
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 500 && reads[1] < 3; c++) step();
    chk("reached_filter1_burst", reads[1] >= 3, 1);
    reset = 1'b1; step();
    chk("midrst_busy", busy, 0);
    chk("midrst_rdreq", src_rdreq, 0);
    chk("midrst_dst_valid", dst_valid, 0);
    reset = 1'b0;
    snap = 0;
    for (int i = 0; i < NF; i++) snap += reads[i];
    for (int c = 0; c < 20; c++) step();
    chk("midrst_stays_idle", busy, 0);
    for (int i = 0; i < NF; i++) snap -= reads[i];
    chk("midrst_no_reads_without_start", snap, 0);
    run_frame(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
